cf_pio_timing_engine: RTL and testbench

//  Next-generation CompactFlash/ATA PIO cycle generator for the COMET 68000 CF card. Replaces fixed

---
 rtl/cf_pio_pkg.sv | 35 +++
 rtl/cf_sync.sv | 24 ++
 rtl/cf_pio_timing_engine.sv | 199 +++++++++++++++++++
 tb/tb_cf_pio_timing_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cf_pio_pkg.sv
// Shared types and constants for the CompactFlash PIO timing engine.
// Holds the FSM state encoding, the timing-table entry layout and the power-on table.
package cf_pio_pkg;

  localparam int unsigned PIO_CNT_BITS = 5;
  localparam logic [2:0]  FC_SUP_DATA  = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_HOLD,
    ST_RECOV
  } pio_state_t;

  typedef struct packed {
    logic [PIO_CNT_BITS-1:0] setup;
    logic [PIO_CNT_BITS-1:0] active;
    logic [PIO_CNT_BITS-1:0] recov;
  } pio_timing_t;

  localparam pio_timing_t PIO0_TIMING = '{setup: 5'd3, active: 5'd7, recov: 5'd15};
  localparam pio_timing_t PIO2_TIMING = '{setup: 5'd2, active: 5'd4, recov: 5'd5};
  localparam pio_timing_t PIO4_TIMING = '{setup: 5'd1, active: 5'd3, recov: 5'd2};

  // Power-on contents of the timing table; entry 3 mirrors the slowest mode.
  function automatic pio_timing_t default_timing(input logic [1:0] idx);
    case (idx)
      2'd1:    return PIO2_TIMING;
      2'd2:    return PIO4_TIMING;
      default: return PIO0_TIMING;
    endcase
  endfunction

endpackage

// File: rtl/cf_sync.sv
// Two-flop synchroniser for asynchronous bus and card inputs.
// Resets to all ones so active-low inputs come up negated.
module cf_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cf_pio_timing_engine.sv
// CompactFlash PIO cycle generator: programmable setup/active/recovery timing,
// IORDY wait insertion with a sticky timeout, and abort when the card select drops.
module cf_pio_timing_engine
  import cf_pio_pkg::*;
#(
  parameter int unsigned CNT_BITS = PIO_CNT_BITS,
  parameter int unsigned TMO_BITS = 10,
  parameter bit          IORDY_EN = 1'b1
) (
  input  logic                osc_40mhz,
  input  logic                n_reset,
  input  logic                n_sel,
  input  logic                n_uds,
  input  logic                n_lds,
  input  logic                n_write,
  input  logic [2:0]          fc,
  input  logic [1:0]          addr,
  input  logic [1:0]          mode,
  input  logic                cfg_wr,
  input  logic [1:0]          cfg_idx,
  input  logic [CNT_BITS-1:0] cfg_setup,
  input  logic [CNT_BITS-1:0] cfg_active,
  input  logic [CNT_BITS-1:0] cfg_recov,
  input  logic                iordy,
  output logic                n_cs0,
  output logic                n_cs1,
  output logic                n_rd,
  output logic                n_wr,
  output logic                cf_ddir,
  output logic                n_dtack_drv,
  output logic                busy,
  output logic                timeout_err
);

  // Last wait clock before the timeout fires: the 2**TMO_BITS-1'th waiting clock.
  localparam logic [TMO_BITS-1:0] TMO_TRIP = {{(TMO_BITS-1){1'b1}}, 1'b0};

  // Count value loaded on phase entry; a programmed 0 behaves like 1.
  function automatic logic [CNT_BITS-1:0] load_val(input logic [PIO_CNT_BITS-1:0] f);
    logic [CNT_BITS-1:0] v;
    v = CNT_BITS'(f);
    return (v == '0) ? '0 : v - CNT_BITS'(1);
  endfunction

  logic [3:0] sync_q;
  logic       sel_s;
  logic       strb;
  logic       ready_s;
  logic       start;

  cf_sync #(.W(4)) u_sync (
    .clk   (osc_40mhz),
    .rst_n (n_reset),
    .d     ({n_sel, n_uds, n_lds, iordy}),
    .q     (sync_q)
  );

  assign sel_s   = sync_q[3];
  assign strb    = !sync_q[2] || !sync_q[1];
  assign ready_s = sync_q[0] | ~IORDY_EN;
  assign start   = !sel_s && (fc == FC_SUP_DATA) && !addr[1];

  pio_timing_t table_q [4];

  // Timing table; writes land immediately but only take effect at the next cycle start.
  always_ff @(posedge osc_40mhz or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 4; i++) table_q[i] <= default_timing(2'(i));
    end else if (cfg_wr) begin
      table_q[cfg_idx] <= '{setup:  PIO_CNT_BITS'(cfg_setup),
                            active: PIO_CNT_BITS'(cfg_active),
                            recov:  PIO_CNT_BITS'(cfg_recov)};
    end
  end

  pio_state_t          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] act_q, act_d;
  logic [CNT_BITS-1:0] rec_q, rec_d;
  logic [TMO_BITS-1:0] tmo_q, tmo_d;
  logic                rd_q, rd_d;
  logic                a4_q, a4_d;
  logic                err_d;
  logic                cnt_done;
  logic                in_xfer;
  logic                cs0_d, cs1_d, rd_n_d, wr_n_d, ddir_d, dtack_d, busy_d;

  always_ff @(posedge osc_40mhz or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      act_q       <= '0;
      rec_q       <= '0;
      tmo_q       <= '0;
      rd_q        <= 1'b0;
      a4_q        <= 1'b0;
      timeout_err <= 1'b0;
      n_cs0       <= 1'b1;
      n_cs1       <= 1'b1;
      n_rd        <= 1'b1;
      n_wr        <= 1'b1;
      cf_ddir     <= 1'b1;
      n_dtack_drv <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      rec_q       <= rec_d;
      tmo_q       <= tmo_d;
      rd_q        <= rd_d;
      a4_q        <= a4_d;
      timeout_err <= err_d;
      n_cs0       <= cs0_d;
      n_cs1       <= cs1_d;
      n_rd        <= rd_n_d;
      n_wr        <= wr_n_d;
      cf_ddir     <= ddir_d;
      n_dtack_drv <= dtack_d;
      busy        <= busy_d;
    end
  end

  // Next state, shared phase counter, and output decode of the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    rec_d    = rec_q;
    tmo_d    = tmo_q;
    rd_d     = rd_q;
    a4_d     = a4_q;
    err_d    = timeout_err;
    cnt_done = (cnt_q == '0);

    if (cfg_wr) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          rd_d    = n_write;
          a4_d    = addr[0];
          cnt_d   = load_val(table_q[mode].setup);
          act_d   = load_val(table_q[mode].active);
          rec_d   = load_val(table_q[mode].recov);
        end
      end
      ST_SETUP: begin
        if (sel_s) begin
          state_d = ST_RECOV;
          cnt_d   = rec_q;
        end else if (!cnt_done) begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end else if (strb) begin
          state_d = ST_ACTIVE;
          cnt_d   = act_q;
          tmo_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (sel_s) begin
          state_d = ST_RECOV;
          cnt_d   = rec_q;
        end else if (!cnt_done) begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end else if (ready_s) begin
          state_d = ST_HOLD;
        end else if (tmo_q == TMO_TRIP) begin
          state_d = ST_HOLD;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_BITS'(1);
        end
      end
      ST_HOLD: begin
        if (sel_s || !strb) begin
          state_d = ST_RECOV;
          cnt_d   = rec_q;
        end
      end
      ST_RECOV: begin
        if (!cnt_done) cnt_d = cnt_q - CNT_BITS'(1);
        else           state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_xfer = (state_d == ST_SETUP) || (state_d == ST_ACTIVE) || (state_d == ST_HOLD);
    cs0_d   = !(in_xfer && !a4_d);
    cs1_d   = !(in_xfer && a4_d);
    rd_n_d  = !(rd_d && ((state_d == ST_ACTIVE) || (state_d == ST_HOLD)));
    wr_n_d  = !(!rd_d && (state_d == ST_ACTIVE));
    ddir_d  = !(rd_d && in_xfer);
    dtack_d = !(state_d == ST_HOLD);
    busy_d  = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_cf_pio_timing_engine.sv
// Bench for cf_pio_timing_engine: directed and randomized PIO cycles checked
// against phase lengths computed from the timing table model.
module tb_cf_pio_timing_engine;

  logic       clk = 1'b0;
  logic       n_reset, n_sel, n_uds, n_lds, n_write, cfg_wr, iordy;
  logic [2:0] fc;
  logic [1:0] addr, mode, cfg_idx;
  logic [4:0] cfg_setup, cfg_active, cfg_recov;
  logic       n_cs0, n_cs1, n_rd, n_wr, cf_ddir, n_dtack_drv, busy, timeout_err;

  int vectors    = 0;
  int miscompares = 0;
  int mt [4][3];
  bit err_m;

  cf_pio_timing_engine dut (
    .osc_40mhz   (clk),
    .n_reset     (n_reset),
    .n_sel       (n_sel),
    .n_uds       (n_uds),
    .n_lds       (n_lds),
    .n_write     (n_write),
    .fc          (fc),
    .addr        (addr),
    .mode        (mode),
    .cfg_wr      (cfg_wr),
    .cfg_idx     (cfg_idx),
    .cfg_setup   (cfg_setup),
    .cfg_active  (cfg_active),
    .cfg_recov   (cfg_recov),
    .iordy       (iordy),
    .n_cs0       (n_cs0),
    .n_cs1       (n_cs1),
    .n_rd        (n_rd),
    .n_wr        (n_wr),
    .cf_ddir     (cf_ddir),
    .n_dtack_drv (n_dtack_drv),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic reset_model();
    mt[0] = '{3, 7, 15};
    mt[1] = '{2, 4, 5};
    mt[2] = '{1, 3, 2};
    mt[3] = '{3, 7, 15};
    err_m = 1'b0;
  endtask

  // Active length: first clock k >= programmed length where the double-synchronised
  // IORDY is high; IORDY driven low for iw clocks from the first active clock is
  // seen low during active clocks 3..iw+2. The 1023rd waiting clock times out.
  function automatic int exp_active(input int a, input int iw, output bit tout);
    int k = a;
    int w = 0;
    tout = 1'b0;
    while (iw > 0 && k >= 3 && k <= iw + 2) begin
      w++;
      if (w == 1023) begin
        tout = 1'b1;
        break;
      end
      k++;
    end
    return k;
  endfunction

  task automatic tick();
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input int s, input int a, input int r);
    cfg_idx    = 2'(idx);
    cfg_setup  = 5'(s);
    cfg_active = 5'(a);
    cfg_recov  = 5'(r);
    cfg_wr     = 1'b1;
    mt[idx]    = '{s, a, r};
    err_m      = 1'b0;
    tick();
  endtask

  task automatic release_bus();
    n_sel = 1'b1;
    n_uds = 1'b1;
    n_lds = 1'b1;
  endtask

  task automatic do_cycle(input bit rd, input bit a4, input int md, input int hold_d,
                          input int iw, input bit cfg_mid, input bit abort);
    int  s_exp, a_exp, r_exp, act_exp, n, j, lat, pick;
    bit  tout;
    s_exp   = eff(mt[md][0]);
    a_exp   = eff(mt[md][1]);
    r_exp   = eff(mt[md][2]);
    act_exp = abort ? 3 : exp_active(a_exp, iw, tout);
    if (abort) tout = 1'b0;

    pick    = int'($urandom_range(0, 2));
    n_sel   = 1'b0;
    n_uds   = (pick == 2);
    n_lds   = (pick == 1);
    n_write = rd;
    fc      = 3'b101;
    addr    = {1'b0, a4};
    mode    = 2'(md);

    lat = 0;
    do begin
      tick();
      lat++;
    end while (!busy && lat < 10);
    check_val("start_latency", lat, 3);
    check_val("setup_cs0", int'(n_cs0), int'(a4));
    check_val("setup_cs1", int'(n_cs1), int'(!a4));
    check_val("setup_ddir", int'(cf_ddir), rd ? 0 : 1);

    n = 0;
    while (busy && n_rd && n_wr && n_dtack_drv && n < 100) begin
      n++;
      tick();
    end
    check_val("setup_len", n, s_exp);
    check_val(rd ? "active_nrd" : "active_nwr", rd ? int'(n_rd) : int'(n_wr), 0);

    n = 0;
    j = 0;
    while (!(n_rd && n_wr) && n_dtack_drv && n < 2000) begin
      if (j == 0) begin
        if (abort) release_bus();
        if (cfg_mid) begin
          cfg_idx    = 2'd3;
          cfg_setup  = 5'd1;
          cfg_active = 5'd1;
          cfg_recov  = 5'd1;
          cfg_wr     = 1'b1;
          mt[3]      = '{1, 1, 1};
          err_m      = 1'b0;
        end
        if (iw > 0) iordy = 1'b0;
      end
      if (j == iw) iordy = 1'b1;
      n++;
      j++;
      tick();
    end
    iordy = 1'b1;
    check_val("active_len", n, act_exp);

    if (abort) begin
      check_val("abort_dtack", int'(n_dtack_drv), 1);
      check_val("abort_strobes", int'({n_rd, n_wr}), 3);
    end else begin
      err_m = err_m | tout;
      check_val("hold_nrd", int'(n_rd), rd ? 0 : 1);
      check_val("hold_nwr", int'(n_wr), 1);
      check_val("hold_cs", int'({n_cs1, n_cs0}), a4 ? 1 : 2);
      check_val("timeout_err", int'(timeout_err), int'(err_m));
      n = 0;
      while (!n_dtack_drv && n < 100) begin
        if (n == hold_d) release_bus();
        n++;
        tick();
      end
      check_val("hold_len", n, 3 + hold_d);
    end

    check_val("recov_cs_ddir", int'({n_cs0, n_cs1, cf_ddir}), 7);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check_val("recov_len", n, r_exp);
  endtask

  task automatic reject_test(input logic [2:0] f, input logic [1:0] a);
    int n = 0;
    n_sel   = 1'b0;
    n_uds   = 1'b0;
    n_lds   = 1'b0;
    n_write = 1'b1;
    fc      = f;
    addr    = a;
    repeat (8) begin
      tick();
      if (busy) n++;
    end
    check_val("reject_busy", n, 0);
    release_bus();
    fc = 3'b101;
    repeat (3) tick();
  endtask

  initial begin
    n_reset    = 1'b0;
    n_write    = 1'b1;
    fc         = 3'b101;
    addr       = 2'b00;
    mode       = 2'd0;
    cfg_wr     = 1'b0;
    cfg_idx    = 2'd0;
    cfg_setup  = 5'd0;
    cfg_active = 5'd0;
    cfg_recov  = 5'd0;
    iordy      = 1'b1;
    release_bus();
    reset_model();
    repeat (3) tick();
    check_val("rst_strobes", int'({n_cs0, n_cs1, n_rd, n_wr, cf_ddir, n_dtack_drv}), 63);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_err", int'(timeout_err), 0);
    n_reset = 1'b1;
    tick();

    do_cycle(1'b1, 1'b0, 0, 2, 0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, 1, 1, 20, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 1, 0, 5000, 1'b0, 1'b0);
    check_val("err_sticky", int'(timeout_err), 1);
    cfg_write(1, 2, 4, 5);
    check_val("err_clear", int'(timeout_err), 0);
    do_cycle(1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b0, 3, 0, 0, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 3, 0, 0, 1'b0, 1'b0);
    reject_test(3'b001, 2'b00);
    reject_test(3'b101, 2'b10);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                  int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 0,
               1'b0, 1'b0);
    end

    n_sel   = 1'b0;
    n_uds   = 1'b0;
    n_write = 1'b1;
    fc      = 3'b101;
    addr    = 2'b00;
    mode    = 2'd0;
    repeat (7) tick();
    check_val("midcyc_busy", int'(busy), 1);
    n_reset = 1'b0;
    #1;
    check_val("midcyc_rst_busy", int'(busy), 0);
    check_val("midcyc_rst_strobes", int'({n_cs0, n_rd, n_dtack_drv}), 7);
    release_bus();
    repeat (2) tick();
    n_reset = 1'b1;
    reset_model();
    tick();
    do_cycle(1'b1, 1'b0, 0, 1, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
